// File: rtl/breath_pkg.sv
// Shared types and widths for the breathing-LED sequencer.
package breath_pkg;

  localparam int unsigned LVL_W       = 10;
  localparam int unsigned HOLD_W      = 16;
  localparam int unsigned CYC_W       = 8;
  localparam int unsigned GAMMA_SHIFT = 10;

  typedef enum logic [2:0] {
    StIdle,
    StRise,
    StHoldHi,
    StFall,
    StHoldLo
  } breath_state_e;

endpackage

// File: rtl/breath_timebase.sv
// 1 us prescaler plus PWM frame counter; frame_tick_o marks the last clock of a frame.
module breath_timebase #(
  parameter logic [5:0] CNT_1US_MAX = 6'd49,
  parameter logic [9:0] CNT_1MS_MAX = 10'd999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       clr_i,
  output logic [9:0] cnt_pwm_o,
  output logic       frame_tick_o
);

  logic [5:0] cnt_us_q, cnt_us_d;
  logic [9:0] cnt_pwm_q, cnt_pwm_d;
  logic       us_wrap;

  assign us_wrap = (cnt_us_q == CNT_1US_MAX);

  always_comb begin
    cnt_us_d  = us_wrap ? 6'd0 : cnt_us_q + 6'd1;
    cnt_pwm_d = cnt_pwm_q;
    if (us_wrap) begin
      cnt_pwm_d = (cnt_pwm_q == CNT_1MS_MAX) ? 10'd0 : cnt_pwm_q + 10'd1;
    end
    if (clr_i) begin
      cnt_us_d  = 6'd0;
      cnt_pwm_d = 10'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_us_q  <= 6'd0;
      cnt_pwm_q <= 10'd0;
    end else begin
      cnt_us_q  <= cnt_us_d;
      cnt_pwm_q <= cnt_pwm_d;
    end
  end

  assign cnt_pwm_o    = cnt_pwm_q;
  assign frame_tick_o = us_wrap && (cnt_pwm_q == CNT_1MS_MAX);

endmodule

// File: rtl/breath_seq_ctrl.sv
// Breathing-LED sequencer: ramp up, hold, ramp down, hold, for N cycles, driving a PWM pin.
// Optional BREATH_GAMMA_EN squares the level before the PWM compare.
module breath_seq_ctrl
  import breath_pkg::*;
#(
  parameter logic [5:0] CNT_1US_MAX    = 6'd49,
  parameter logic [9:0] CNT_1MS_MAX    = 10'd999,
  parameter logic       LED_ACTIVE_LOW = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold_hi,
  input  logic [HOLD_W-1:0] cfg_hold_lo,
  input  logic [CYC_W-1:0]  cfg_cycles,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [LVL_W-1:0]  level,
  output logic              led_out
);

  breath_state_e     state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic              led_q, led_d;

  logic [7:0]        cfg_step_q;
  logic [HOLD_W-1:0] cfg_hold_hi_q, cfg_hold_lo_q;
  logic [CYC_W-1:0]  cfg_cycles_q;

  logic [9:0]        cnt_pwm;
  logic              frame_tick;
  logic              start_ok, stop_now, cfg_fire;
  logic [7:0]        step_eff;
  logic [LVL_W:0]    rise_sum;
  logic              rise_sat;
  logic [LVL_W-1:0]  rise_lvl, fall_lvl, duty;
  logic [CYC_W-1:0]  cyc_next;
  logic              lit;

  assign busy      = (state_q != StIdle);
  assign cfg_ready = (state_q == StIdle);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign start_ok  = (state_q == StIdle) && start && !stop;
  assign stop_now  = stop_pend_q || stop;

  breath_timebase #(
    .CNT_1US_MAX (CNT_1US_MAX),
    .CNT_1MS_MAX (CNT_1MS_MAX)
  ) u_timebase (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .clr_i        (start_ok),
    .cnt_pwm_o    (cnt_pwm),
    .frame_tick_o (frame_tick)
  );

  // A zero step would stall the ramp forever, so it behaves as 1.
  assign step_eff = (cfg_step_q == 8'd0) ? 8'd1 : cfg_step_q;
  assign rise_sum = {1'b0, level_q} + {3'b000, step_eff};
  assign rise_sat = (rise_sum >= {1'b0, CNT_1MS_MAX});
  assign rise_lvl = rise_sat ? CNT_1MS_MAX : rise_sum[LVL_W-1:0];
  assign fall_lvl = (level_q > {2'b00, step_eff}) ? level_q - {2'b00, step_eff} : '0;
  assign cyc_next = cycle_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    stop_pend_d = stop_pend_q || stop;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (start_ok) begin
          state_d     = StRise;
          level_d     = '0;
          cycle_cnt_d = '0;
        end
      end
      StRise: begin
        if (frame_tick) begin
          if (stop_now) begin
            state_d = StFall;
          end else begin
            level_d = rise_lvl;
            if (rise_sat) begin
              state_d    = StHoldHi;
              hold_cnt_d = '0;
            end
          end
        end
      end
      StHoldHi: begin
        if (frame_tick) begin
          if (stop_now || (hold_cnt_q == cfg_hold_hi_q)) begin
            state_d = StFall;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
      end
      StFall: begin
        if (frame_tick) begin
          level_d = fall_lvl;
          if (fall_lvl == '0) begin
            state_d    = StHoldLo;
            hold_cnt_d = '0;
          end
        end
      end
      StHoldLo: begin
        // A pending stop leaves immediately rather than waiting out the hold.
        if (stop_now) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (frame_tick) begin
          if (hold_cnt_q == cfg_hold_lo_q) begin
            cycle_cnt_d = cyc_next;
            if ((cfg_cycles_q != '0) && (cyc_next == cfg_cycles_q)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StRise;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef BREATH_GAMMA_EN
  logic [2*LVL_W-1:0] lvl_sq;
  assign lvl_sq = level_q * level_q;
  assign duty   = lvl_sq[GAMMA_SHIFT +: LVL_W];
`else
  assign duty = level_q;
`endif

  assign lit   = busy && (cnt_pwm < duty);
  assign led_d = lit ^ LED_ACTIVE_LOW;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      level_q       <= '0;
      hold_cnt_q    <= '0;
      cycle_cnt_q   <= '0;
      stop_pend_q   <= 1'b0;
      done_q        <= 1'b0;
      led_q         <= LED_ACTIVE_LOW;
      cfg_step_q    <= 8'd1;
      cfg_hold_hi_q <= '0;
      cfg_hold_lo_q <= '0;
      cfg_cycles_q  <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      led_q       <= led_d;
      if (cfg_fire) begin
        cfg_step_q    <= cfg_step;
        cfg_hold_hi_q <= cfg_hold_hi;
        cfg_hold_lo_q <= cfg_hold_lo;
        cfg_cycles_q  <= cfg_cycles;
      end
    end
  end

  assign done    = done_q;
  assign level   = level_q;
  assign led_out = led_q;

endmodule
